decoder_38: RTL and testbench

Registered 3-to-8 line decoder with a valid/ready stream on both sides, a 2-entry output buffer and optional per-line hit counters. It is the receive-side counterpart of the 8:3 priority-free encoder: it takes a 3-bit line code and regenerates the one-hot 8-bit line vector. It sits between a code producer and any consumer needing one-hot selects, such as mux selects or per-line strobes, and absorbs one cycle of consumer back-pressure without losing throughput.

---
 rtl/decoder_38_pkg.sv | 21 ++
 rtl/decoder_38_fifo2.sv | 56 +++++
 rtl/decoder_38.sv | 74 +++++++
 tb/tb_decoder_38.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/decoder_38_pkg.sv
// Shared constants, line-vector type and the code-to-one-hot helper for decoder_38.
package decoder_38_pkg;

    localparam int CODE_W     = 3;
    localparam int LINES      = 8;
    localparam int FIFO_DEPTH = 2;

    typedef logic [LINES-1:0] line_vec_t;

    // One-hot expansion of a line code; a disabled decode yields all zeros.
    function automatic line_vec_t decode_line(input logic [CODE_W-1:0] code,
                                              input logic              en);
        line_vec_t word;
        word = '0;
        if (en) begin
            word = line_vec_t'(1) << code;
        end
        return word;
    endfunction

endpackage

// File: rtl/decoder_38_fifo2.sv
// Two-entry line-vector FIFO: pointer-based storage with an occupancy count.
// Storage is not reset; only pointers and count are, so head is meaningful
// only while empty is low.
module decoder_38_fifo2
    import decoder_38_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  line_vec_t din,
    output logic      full,
    output logic      empty,
    output line_vec_t head
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    line_vec_t  mem [FIFO_DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    assign full  = (count == DEPTH);
    assign empty = (count == 2'd0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; callers never push when full or pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Word storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/decoder_38.sv
// Registered 3-to-8 line decoder with valid/ready on both sides and a
// 2-entry output buffer. Optional per-line saturating hit counters are
// built when DECODER_38_HIST_EN is defined; otherwise hist_cnt reads 0.
module decoder_38
    import decoder_38_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_en,
    output logic              out_valid,
    input  logic              out_ready,
    output line_vec_t         out_onehot,
    input  logic [CODE_W-1:0] hist_sel,
    input  logic              hist_clr,
    output logic [CNT_W-1:0]  hist_cnt
);

    logic      accept;
    logic      pop;
    logic      full;
    logic      empty;
    line_vec_t head;
    line_vec_t word;

    // Readiness depends only on buffer state and reset, never on out_ready,
    // so a full buffer refuses a push even when it is being drained.
    assign in_ready  = ~full & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign word      = decode_line(in_code, in_en);
    assign out_onehot = empty ? '0 : head;

    decoder_38_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (word),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

`ifdef DECODER_38_HIST_EN
    logic [CNT_W-1:0] hits [LINES];

    // Per-line saturating hit counters; clear overrides a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst || hist_clr) begin
            for (int k = 0; k < LINES; k++) begin
                hits[k] <= '0;
            end
        end else if (accept && in_en) begin
            if (hits[in_code] != '1) begin
                hits[in_code] <= hits[in_code] + 1'b1;
            end
        end
    end

    assign hist_cnt = hits[hist_sel];
`else
    logic unused_hist;

    assign unused_hist = ^{hist_sel, hist_clr};
    assign hist_cnt    = '0;
`endif

endmodule

// File: tb/tb_decoder_38.sv
// Self-checking bench for decoder_38: directed scenarios followed by random
// traffic, compared against a queue-based reference model each cycle.
module tb_decoder_38;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_code;
    logic             in_en;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_onehot;
    logic [2:0]       hist_sel;
    logic             hist_clr;
    logic [CNT_W-1:0] hist_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] q [$];
    int         hits [8];

    decoder_38 #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .hist_sel   (hist_sel),
        .hist_clr   (hist_clr),
        .hist_cnt   (hist_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int hist_expect(input int sel);
`ifdef DECODER_38_HIST_EN
        return hits[sel];
`else
        return 0;
`endif
    endfunction

    // One cycle: drive inputs after the falling edge, check outputs against the
    // model, then advance the model across the rising edge.
    task automatic step(input logic r, input logic v, input int c, input logic e,
                        input logic rdy, input int s, input logic clr);
        logic       exp_rdy;
        logic       acc;
        logic       pp;
        logic [7:0] exp_word;
        rst       = r;
        in_valid  = v;
        in_code   = v ? 3'(c) : 3'bxxx;
        in_en     = e;
        out_ready = rdy;
        hist_sel  = 3'(s);
        hist_clr  = clr;
        #1;
        exp_rdy = (q.size() < 2) && !r;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        exp_word = (q.size() != 0) ? q[0] : 8'h00;
        check("out_onehot", 32'(out_onehot), 32'(exp_word));
        check("hist_cnt", 32'(hist_cnt), 32'(hist_expect(s)));
        acc = v && exp_rdy;
        pp  = (q.size() != 0) && rdy;
        @(posedge clk);
        if (r) begin
            q.delete();
            foreach (hits[k]) hits[k] = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e ? 8'(1 << c) : 8'h00);
            if (clr) begin
                foreach (hits[k]) hits[k] = 0;
            end else if (acc && e && hits[c] < CMAX) begin
                hits[c] = hits[c] + 1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        foreach (hits[k]) hits[k] = 0;
        rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; in_en = 1'b0;
        out_ready = 1'b0; hist_sel = 3'd0; hist_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held; an offered code must be ignored.
        step(1, 1, 3, 1, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);

        // Stream 0..7 with continuous drain.
        for (int i = 0; i < 8; i++) step(0, 1, i, 1, 1, i, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // Disabled decode produces an all-zero valid word and no hit.
        step(0, 1, 5, 0, 1, 5, 0);
        step(0, 0, 0, 0, 1, 5, 0);
        step(0, 0, 0, 0, 1, 5, 0);

        // Back-pressure: offer 3,6,1 with out_ready low; only two fit.
        step(0, 1, 3, 1, 0, 0, 0);
        step(0, 1, 6, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0);
        check("stall_hold", 32'(out_onehot), 32'h08);
        check("stall_full", 32'(in_ready), 32'h0);
        // Full with pop and push offered together: pop only.
        step(0, 1, 1, 1, 1, 0, 0);
        check("after_pop_ready", 32'(in_ready), 32'h1);
        check("after_pop_head", 32'(out_onehot), 32'h40);
        step(0, 1, 1, 1, 1, 0, 0);
        check("deliver_02", 32'(out_onehot), 32'h02);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // Counter saturation and clear-wins on code 7.
        step(1, 0, 0, 0, 1, 7, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 7, 1, 1, 7, 0);
`ifdef DECODER_38_HIST_EN
        check("sat7", 32'(hist_cnt), 32'(CMAX));
`else
        check("hist_off", 32'(hist_cnt), 32'h0);
`endif
        step(0, 1, 7, 1, 1, 7, 1);
        check("clr7", 32'(hist_cnt), 32'h0);
        step(0, 0, 0, 0, 1, 7, 0);

        // Reset mid-stream with two buffered words.
        step(0, 1, 2, 1, 0, 0, 0);
        step(0, 1, 4, 1, 0, 0, 0);
        step(1, 1, 6, 1, 0, 0, 0);
        check("rst_flush_valid", 32'(out_valid), 32'h0);
        check("rst_flush_data", 32'(out_onehot), 32'h0);
        step(0, 0, 0, 0, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
